// File: rtl/grf_pkg.sv
// General register file shared definitions: register indices and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package grf_pkg;

  // Architectural register indices with special meaning.
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Default geometry of the MIPS GRF.
  localparam int NUM_REGS   = 32;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int PC_W       = 32;

endpackage : grf_pkg

// File: rtl/grf_if.sv
// Write-back / operand-read bundle between the datapath and the register file.
// Latency: n/a (wiring only).
// Backpressure: none; the register file accepts a write every cycle.
interface grf_if
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  // Write side (RegWrite / RegDst / MemtoReg results)
  logic              we;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] wdata;
  logic [PC_W-1:0]   pc;

  // Operand read side (rs / rt)
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Commit trace and statistics
  logic              trace_valid;
  logic [PC_W-1:0]   trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [CNT_W-1:0]  write_count;

  // Datapath side: drives writes and read indices, observes results.
  modport master (
    output we, addr_w, wdata, pc, ra1, ra2,
    input  rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data, write_count
  );

  // Register file side.
  modport slave (
    input  we, addr_w, wdata, pc, ra1, ra2,
    output rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data, write_count
  );

endinterface : grf_if

// File: rtl/grf_read_port.sv
// One GRF read port: index mux, register-0 zero force and optional write bypass.
// Latency: combinational.
// Backpressure: none.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0]                    ra,
  input  logic                                 we,
  input  logic [ADDR_W-1:0]                    addr_w,
  input  logic [DATA_W-1:0]                    wdata,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
  output logic [DATA_W-1:0]                    rd
);

  logic hit;

  // A read of the register being written this cycle sees the new value when bypass is on.
  assign hit = BYPASS && we && (addr_w == ra);

  // Register 0 is hardwired to zero regardless of stored contents or bypass.
  always_comb begin
    rd = regs[ra];
    if (ra == ADDR_W'(REG_ZERO)) begin
      rd = '0;
    end else if (hit) begin
      rd = wdata;
    end
  end

endmodule : grf_read_port

// File: rtl/grf_write_port.sv
// MIPS general register file: one write port, two bypassable read ports, commit trace and write counter.
// Latency: writes commit on the rising edge; reads are combinational; trace appears one cycle after the write.
// Backpressure: none; a write is accepted every cycle that we is high.
module grf_write_port
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic  clk,
  input  logic  reset,
  grf_if.slave  bus
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;

  logic              trace_valid;
  logic [PC_W-1:0]   trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [CNT_W-1:0]  write_count;

  logic              wr_zero;
  logic              commit;
  logic [DATA_W-1:0] stored_data;
  logic              cnt_full;

  // Writes to index 0 are traced but never stored or counted.
  assign wr_zero     = (bus.addr_w == ADDR_W'(REG_ZERO));
  assign commit      = bus.we && !wr_zero;
  assign stored_data = wr_zero ? '0 : bus.wdata;
  assign cnt_full    = &write_count;

  // Register array, commit trace and saturating write counter share one reset domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs        <= '0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
      write_count <= '0;
    end else begin
      if (commit) begin
        regs[bus.addr_w] <= bus.wdata;
        if (!cnt_full) begin
          write_count <= write_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      trace_valid <= bus.we;
      if (bus.we) begin
        trace_pc   <= bus.pc;
        trace_addr <= bus.addr_w;
        trace_data <= stored_data;
      end
    end
  end

  assign bus.trace_valid = trace_valid;
  assign bus.trace_pc    = trace_pc;
  assign bus.trace_addr  = trace_addr;
  assign bus.trace_data  = trace_data;
  assign bus.write_count = write_count;

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rp1 (
    .ra     (bus.ra1),
    .we     (bus.we),
    .addr_w (bus.addr_w),
    .wdata  (bus.wdata),
    .regs   (regs),
    .rd     (bus.rd1)
  );

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rp2 (
    .ra     (bus.ra2),
    .we     (bus.we),
    .addr_w (bus.addr_w),
    .wdata  (bus.wdata),
    .regs   (regs),
    .rd     (bus.rd2)
  );

endmodule : grf_write_port

// File: tb/tb_grf_write_port.sv
// Bench for grf_write_port: two instances (bypass with 16-bit counter, no bypass with 2-bit counter)
// share identical stimulus and are compared against a behavioural register-file model.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_grf_write_port;

  logic clk;
  logic reset;

  grf_if #(.CNT_W(16)) ifa ();
  grf_if #(.CNT_W(2))  ifb ();

  grf_write_port #(.BYPASS(1'b1), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  grf_write_port #(.BYPASS(1'b0), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus currently presented to both instances
  logic        d_we;
  logic [4:0]  d_aw;
  logic [31:0] d_wd;
  logic [31:0] d_pc;
  logic [4:0]  d_ra1;
  logic [4:0]  d_ra2;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_tv;
  logic [31:0] m_tpc;
  logic [4:0]  m_taddr;
  logic [31:0] m_tdata;
  int          m_cnt_a;
  int          m_cnt_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    ifa.we = d_we; ifa.addr_w = d_aw; ifa.wdata = d_wd; ifa.pc = d_pc;
    ifa.ra1 = d_ra1; ifa.ra2 = d_ra2;
    ifb.we = d_we; ifb.addr_w = d_aw; ifb.wdata = d_wd; ifb.pc = d_pc;
    ifb.ra1 = d_ra1; ifb.ra2 = d_ra2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_tv = 1'b0; m_tpc = '0; m_taddr = '0; m_tdata = '0;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // Architectural view of a read: register 0 is zero, a same-cycle write is visible only with bypass.
  function automatic logic [31:0] mread(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && d_we && d_aw == idx) return d_wd;
    return m_regs[idx];
  endfunction

  // What a rising edge does to the architectural state, given the presented stimulus.
  task automatic model_edge();
    if (reset) begin
      m_tv = d_we;
      if (d_we) begin
        m_tpc   = d_pc;
        m_taddr = d_aw;
        m_tdata = (d_aw == 5'd0) ? 32'd0 : d_wd;
      end
      if (d_we && d_aw != 5'd0) begin
        m_regs[d_aw] = d_wd;
        m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
        m_cnt_b = (m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1;
      end
    end
  endtask

  task automatic check_reads(input string tag);
    chk({tag, "_a_rd1"}, ifa.rd1, mread(d_ra1, 1'b1));
    chk({tag, "_a_rd2"}, ifa.rd2, mread(d_ra2, 1'b1));
    chk({tag, "_b_rd1"}, ifb.rd1, mread(d_ra1, 1'b0));
    chk({tag, "_b_rd2"}, ifb.rd2, mread(d_ra2, 1'b0));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_a_tvalid"}, ifa.trace_valid, m_tv);
    chk({tag, "_a_tpc"},    ifa.trace_pc,    m_tpc);
    chk({tag, "_a_taddr"},  ifa.trace_addr,  m_taddr);
    chk({tag, "_a_tdata"},  ifa.trace_data,  m_tdata);
    chk({tag, "_a_count"},  ifa.write_count, 64'(m_cnt_a));
    chk({tag, "_b_tvalid"}, ifb.trace_valid, m_tv);
    chk({tag, "_b_tpc"},    ifb.trace_pc,    m_tpc);
    chk({tag, "_b_taddr"},  ifb.trace_addr,  m_taddr);
    chk({tag, "_b_tdata"},  ifb.trace_data,  m_tdata);
    chk({tag, "_b_count"},  ifb.write_count, 64'(m_cnt_b));
  endtask

  // One clock of stimulus: combinational reads before the edge, state and reads after it.
  task automatic cycle(input string tag, input logic w, input logic [4:0] aw, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2);
    d_we = w; d_aw = aw; d_wd = wd; d_pc = pc; d_ra1 = r1; d_ra2 = r2;
    apply();
    #1;
    if (w) chk({tag, "_x_in"}, 64'($isunknown({aw, wd})), 64'd0);
    check_reads({tag, "_pre"});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_reads({tag, "_post"});
    check_state(tag);
  endtask

  int exp_seq[5] = '{1, 2, 3, 3, 3};
  logic [31:0] last_wd;

  initial begin
    d_we = 0; d_aw = 0; d_wd = 0; d_pc = 0; d_ra1 = 0; d_ra2 = 0;
    reset = 1'b0;
    apply();
    model_reset();
    #2;
    check_state("reset0");
    check_reads("reset0");
    @(negedge clk);
    reset = 1'b1;

    // Basic write to r8 with trace
    cycle("w8", 1'b1, 5'd8, 32'h1234_5678, 32'h3000, 5'd8, 5'd0);
    chk("w8_rd1", ifa.rd1, 64'h1234_5678);
    chk("w8_tvalid", ifa.trace_valid, 64'd1);
    chk("w8_tpc", ifa.trace_pc, 64'h3000);
    chk("w8_taddr", ifa.trace_addr, 64'd8);
    chk("w8_count", ifa.write_count, 64'd1);

    // Write to r0 is traced with zero data and not counted
    cycle("w0", 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3004, 5'd0, 5'd0);
    chk("w0_rd1", ifa.rd1, 64'd0);
    chk("w0_tvalid", ifa.trace_valid, 64'd1);
    chk("w0_tdata", ifa.trace_data, 64'd0);
    chk("w0_count", ifa.write_count, 64'd1);

    // Idle cycle: trace pulse drops, trace fields hold
    cycle("idle", 1'b0, 5'd9, 32'h0BAD_0BAD, 32'h3008, 5'd8, 5'd8);
    chk("idle_tvalid", ifa.trace_valid, 64'd0);

    // Same-cycle bypass on both ports vs. old value without bypass
    cycle("w5a", 1'b1, 5'd5, 32'h1111_2222, 32'h300C, 5'd1, 5'd2);
    d_we = 1'b1; d_aw = 5'd5; d_wd = 32'hA5A5_A5A5; d_pc = 32'h3010; d_ra1 = 5'd5; d_ra2 = 5'd5;
    apply();
    #1;
    chk("byp_a_rd1", ifa.rd1, 64'hA5A5_A5A5);
    chk("byp_a_rd2", ifa.rd2, 64'hA5A5_A5A5);
    chk("byp_b_rd1", ifb.rd1, 64'h1111_2222);
    chk("byp_b_rd2", ifb.rd2, 64'h1111_2222);
    check_reads("byp");
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_reads("byp_post");
    chk("byp_b_after", ifb.rd1, 64'hA5A5_A5A5);
    check_state("byp");

    // Asynchronous reset mid-run, then sweep every index
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_state("rst1");
    chk("rst1_tvalid", ifa.trace_valid, 64'd0);
    chk("rst1_count", ifa.write_count, 64'd0);
    for (int i = 0; i < 32; i++) begin
      d_we = 1'b0; d_ra1 = 5'(i); d_ra2 = 5'(31 - i);
      apply();
      #1;
      check_reads("rst1_sweep");
    end
    @(negedge clk);
    reset = 1'b1;

    // Reset asserted 2 ns before an edge discards the pending write to r31
    cycle("pre31", 1'b1, 5'd4, 32'h4444_4444, 32'h3100, 5'd4, 5'd0);
    d_we = 1'b1; d_aw = 5'd31; d_wd = 32'hDEAD_BEEF; d_pc = 32'h3104; d_ra1 = 5'd31; d_ra2 = 5'd4;
    apply();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("late_rst_tvalid", ifa.trace_valid, 64'd0);
    @(posedge clk);
    @(negedge clk);
    d_we = 1'b0;
    apply();
    #1;
    check_reads("late_rst");
    check_state("late_rst");
    chk("late_rst_r31", ifa.rd1, 64'd0);
    chk("late_rst_count", ifa.write_count, 64'd0);
    // A write presented while reset is released takes effect on that edge
    reset = 1'b1;
    cycle("resume", 1'b1, 5'd31, 32'hCAFE_F00D, 32'h3108, 5'd31, 5'd31);
    chk("resume_r31", ifb.rd1, 64'hCAFE_F00D);
    chk("resume_count", ifb.write_count, 64'd1);

    // Saturation of the 2-bit counter with back-to-back writes to r3
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      last_wd = $urandom;
      cycle("sat", 1'b1, 5'd3, last_wd, 32'h3200 + 32'(4 * k), 5'd3, 5'd0);
      chk("sat_b_count", ifb.write_count, 64'(exp_seq[k]));
      chk("sat_tvalid", ifb.trace_valid, 64'd1);
    end
    chk("sat_r3", ifb.rd1, 64'(last_wd));
    chk("sat_a_count", ifa.write_count, 64'd5);

    // Randomized traffic concentrated on a few indices to provoke collisions
    for (int n = 0; n < 300; n++) begin
      logic [4:0] aw, r1, r2;
      aw = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      r1 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 6));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      cycle("rand", 1'($urandom_range(0, 1)), aw, $urandom, $urandom, r1, r2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_grf_write_port
